// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state and owner
// encodings plus the default latency and address width.
package mem_arbiter_pkg;

    localparam int MEM_LAT_DEF = 1;
    localparam int AW_DEF      = 32;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker: combinational grant, registered
// record of the last requester granted.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_if_i,
    input  logic   req_d_i,
    input  logic   advance_i,
    output logic   valid_o,
    output owner_e grant_o
);

    owner_e last_q;

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        valid_o = req_if_i | req_d_i;
        if (req_if_i && req_d_i) begin
            grant_o = (last_q == OWN_D) ? OWN_IF : OWN_D;
        end else if (req_d_i) begin
            grant_o = OWN_D;
        end else begin
            grant_o = OWN_IF;
        end
    end

    // Starting from "fetch was last" makes data the first winner after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_IF;
        end else if (advance_i && valid_o) begin
            last_q <= grant_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port memory with fixed read latency MEM_LAT.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW      = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ready,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           grant;
    logic             req_valid;
    logic             take;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    assign take = (state_q == ST_IDLE);

    rr_pick2 u_pick (
        .clk       (clk),
        .rst_n     (reset),
        .req_if_i  (if_req),
        .req_d_i   (d_req),
        .advance_i (take),
        .valid_o   (req_valid),
        .grant_o   (grant)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ACCESS;
                    owner_d = grant;
                    if (grant == OWN_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d   = 1'b0;
                        addr_d = if_addr;
                    end
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LAT);
                end
            end
            ST_WAIT: begin
                // Count 1 marks the cycle mem_rdata belongs to this access.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            // NOTE: the read-data holders are plain flops, not a memory, so they reset with the rest.
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking everywhere so every register sees pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ready  = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign d_ready   = (state_q == ST_DONE) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 for the main
// sequence, a second at MEM_LAT=3 for the long-latency fetch.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req3;
    logic [31:0] if_addr3;
    logic        if_ready3, d_ready3, mem_en3, mem_we3, busy3;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic [31:0] pipe3 [0:2];

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_LAT(3), .AW(32)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ready(d_ready3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Read contents: 0x40 holds DEADBEEF, any other address returns C0DE_<addr>.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {16'h0, a[15:0]});
    endfunction

    // One-cycle memory; 0BAD0BAD on every cycle that carries no read data.
    always @(posedge clk) begin
        mem_rdata <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'h0BAD_0BAD;
    end

    // Three-cycle memory: read data of the enable cycle appears three cycles later.
    always @(posedge clk) begin
        pipe3[0] <= (mem_en3 && !mem_we3) ? (32'h3300_0000 ^ mem_addr3) : 32'h0BAD_0003;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata3 = pipe3[2];

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_v;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        if_req3 = 1'b0; if_addr3 = 32'h0;
        #2 reset = 1'b0;

        // Load request already pending while reset is held.
        d_req = 1'b1; d_addr = 32'h40;
        step(); step();
        check1("rst_busy", busy, 1'b0);
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_d_ready", d_ready, 1'b0);
        check1("rst_if_ready", if_ready, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_d_rdata", d_rdata, 32'h0);
        check32("rst_if_rdata", if_rdata, 32'h0);

        // Single load, MEM_LAT=1: release gives cycle N in IDLE.
        reset = 1'b1;
        check1("load_n_idle", busy, 1'b0);
        step();
        check1("load_access_en", mem_en, 1'b1);
        check1("load_access_we", mem_we, 1'b0);
        check32("load_access_addr", mem_addr, 32'h40);
        check1("load_access_ready", d_ready, 1'b0);
        step();
        check1("load_wait_en", mem_en, 1'b0);
        check1("load_wait_ready", d_ready, 1'b0);
        check1("load_wait_busy", busy, 1'b1);
        step();
        check1("load_n3_d_ready", d_ready, 1'b1);
        check1("load_n3_if_ready", if_ready, 1'b0);
        check32("load_rdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        step();
        check1("load_after_ready", d_ready, 1'b0);
        check1("load_after_busy", busy, 1'b0);
        check32("load_rdata_hold", d_rdata, 32'hDEAD_BEEF);

        // Single store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
        step();
        check1("store_en", mem_en, 1'b1);
        check1("store_we", mem_we, 1'b1);
        check32("store_addr", mem_addr, 32'h80);
        check32("store_wdata", mem_wdata, 32'h1234_5678);
        check1("store_access_ready", d_ready, 1'b0);
        step();
        check1("store_n2_ready", d_ready, 1'b1);
        check1("store_done_en", mem_en, 1'b0);
        check1("store_done_we", mem_we, 1'b0);
        check32("store_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        step();
        check1("store_idle_busy", busy, 1'b0);
        check32("store_addr_hold", mem_addr, 32'h80);
        check32("store_wdata_hold", mem_wdata, 32'h1234_5678);

        // Reset during WAIT aborts the load.
        d_req = 1'b1; d_addr = 32'h44;
        step(); step();
        check1("abort_in_wait", busy, 1'b1);
        reset = 1'b0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_en", mem_en, 1'b0);
        check1("abort_ready", d_ready, 1'b0);
        check32("abort_rdata", d_rdata, 32'h0);
        check32("abort_addr", mem_addr, 32'h0);
        d_req = 1'b0;
        step(); step();
        check1("abort_no_ready", d_ready, 1'b0);

        // Contention from reset release: data, fetch, data, fetch.
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        step();
        reset = 1'b1;
        for (int off = 0; off < 16; off++) begin
            exp_v = {(off % 8 == 7), (off % 8 == 3), (off % 4 == 1)};
            check32($sformatf("cont_if_d_en_c%0d", off),
                    {29'd0, if_ready, d_ready, mem_en}, {29'd0, exp_v});
            if (off % 4 == 1)
                check32($sformatf("cont_addr_c%0d", off), mem_addr,
                        (off % 8 == 1) ? 32'h200 : 32'h100);
            if (off == 3) check32("cont_d_rdata", d_rdata, 32'hC0DE_0200);
            if (off == 7) check32("cont_if_rdata", if_rdata, 32'hC0DE_0100);
            if (off == 15) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            step();
        end
        check1("cont_idle", busy, 1'b0);

        // Back-to-back fetches with if_req held across ready.
        if_req = 1'b1; if_addr = 32'h0;
        step();
        check1("b2b_en0", mem_en, 1'b1);
        check32("b2b_addr0", mem_addr, 32'h0);
        step(); step();
        check1("b2b_ready0", if_ready, 1'b1);
        check32("b2b_rdata0", if_rdata, 32'hC0DE_0000);
        if_addr = 32'h4;
        step();
        check1("b2b_idle_en", mem_en, 1'b0);
        check1("b2b_idle_busy", busy, 1'b0);
        step();
        check1("b2b_en1", mem_en, 1'b1);
        check32("b2b_addr1", mem_addr, 32'h4);
        step(); step();
        check1("b2b_ready1", if_ready, 1'b1);
        check1("b2b_no_d_ready", d_ready, 1'b0);
        check32("b2b_rdata1", if_rdata, 32'hC0DE_0004);
        if_req = 1'b0;
        step();
        check1("b2b_end_busy", busy, 1'b0);
        check1("b2b_end_ready", if_ready, 1'b0);

        // MEM_LAT=3 fetch: ready at N+5, data from three cycles after enable.
        if_req3 = 1'b1; if_addr3 = 32'h0;
        step();
        check1("lat3_en", mem_en3, 1'b1);
        step();
        check1("lat3_wait_en", mem_en3, 1'b0);
        step(); step();
        check1("lat3_n4_ready", if_ready3, 1'b0);
        step();
        check1("lat3_n5_ready", if_ready3, 1'b1);
        check32("lat3_rdata", if_rdata3, 32'h3300_0000);
        if_req3 = 1'b0;
        step();
        check1("lat3_idle", busy3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
